// File: rtl/rtdf_pkg.sv
// Shared types and constants for the RTDF receive packet filter.
package rtdf_pkg;

  typedef enum logic [2:0] {
    LENGTH  = 3'd0,
    HEADER  = 3'd1,
    SEQ     = 3'd2,
    DATA    = 3'd3,
    DISCARD = 3'd4
  } rtdf_state_e;

  localparam int HDR_WORDS     = 7;
  localparam int ETH_HDR_BYTES = 14;
  localparam int CRC_BYTES     = 4;
  localparam int SEQ_BYTES     = 2;

  localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88B5;

  // Wire-order 16-bit word idx (0..2) of a MAC address, byte 0 = mac[47:40] in bits [7:0].
  function automatic logic [15:0] mac_wire_word(input logic [47:0] mac, input logic [1:0] idx);
    case (idx)
      2'd0:    return {mac[39:32], mac[47:40]};
      2'd1:    return {mac[23:16], mac[31:24]};
      default: return {mac[7:0], mac[15:8]};
    endcase
  endfunction

endpackage

// File: rtl/rtdf_frame_len_calc.sv
// Frame length arithmetic: word count, payload size and runt test for one length word.
module rtdf_frame_len_calc
  import rtdf_pkg::*;
#(
  parameter int LEN_WIDTH  = 12,
  parameter int CRC_ENABLE = 1,
  parameter int SEQ_ENABLE = 1
) (
  input  logic [LEN_WIDTH-1:0] len,
  output logic [LEN_WIDTH-1:0] frame_words,
  output logic [LEN_WIDTH-1:0] payload_words,
  output logic                 payload_odd,
  output logic                 runt
);

  localparam int OVH = ETH_HDR_BYTES + CRC_BYTES * CRC_ENABLE + SEQ_BYTES * SEQ_ENABLE;
  localparam logic [LEN_WIDTH-1:0] OVH_W = LEN_WIDTH'(OVH);

  logic [LEN_WIDTH-1:0] pay_bytes;

  always_comb begin
    runt          = (len < OVH_W);
    pay_bytes     = runt ? '0 : (len - OVH_W);
    frame_words   = {1'b0, len[LEN_WIDTH-1:1]} + LEN_WIDTH'(len[0]);
    payload_words = {1'b0, pay_bytes[LEN_WIDTH-1:1]} + LEN_WIDTH'(pay_bytes[0]);
    payload_odd   = pay_bytes[0];
  end

endmodule

// File: rtl/rtdf_packet_filter.sv
// Parses length-prefixed Ethernet frames from a show-ahead RX FIFO, filters by
// EtherType/destination, checks sequence numbers and forwards payload words.
module rtdf_packet_filter
  import rtdf_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE     = DEFAULT_ETHERTYPE,
  parameter int          CRC_ENABLE    = 1,
  parameter int          MAC_FILTER_EN = 0,
  parameter logic [47:0] MAC_ADDR      = 48'h0,
  parameter int          SEQ_ENABLE    = 1,
  parameter int          LEN_WIDTH     = 12
) (
  input  logic        clk_rx,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_empty,
  output logic        in_rd_req,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic        out_odd,
  output logic [15:0] packet_count,
  output logic [15:0] good_packet_count,
  output logic [15:0] seq_error_count,
  output logic [15:0] runt_count,
  output logic [2:0]  dbg_state
);

  rtdf_state_e          state;
  logic [LEN_WIDTH-1:0] words_left;
  logic [LEN_WIDTH-1:0] pay_left;
  logic                 pay_odd;
  logic                 first_pend;
  logic                 dst_is_mac;
  logic                 dst_is_bcast;
  logic                 seen_good;
  logic [2:0]           hdr_idx;
  logic [15:0]          seq_expected;

  logic [LEN_WIDTH-1:0] frame_words;
  logic [LEN_WIDTH-1:0] payload_words;
  logic                 payload_odd;
  logic                 runt;

  logic                 consume;
  logic                 words_last;
  logic [15:0]          rx_swapped;
  logic                 frame_drop;

  rtdf_frame_len_calc #(
    .LEN_WIDTH  (LEN_WIDTH),
    .CRC_ENABLE (CRC_ENABLE),
    .SEQ_ENABLE (SEQ_ENABLE)
  ) u_len_calc (
    .len           (in_data[LEN_WIDTH-1:0]),
    .frame_words   (frame_words),
    .payload_words (payload_words),
    .payload_odd   (payload_odd),
    .runt          (runt)
  );

  // Input side: a word moves when in_rd_req && !in_empty. Output side: a word moves
  // when out_valid && out_ready; in DATA a new word is only pulled when the output
  // register is empty or draining this cycle, so held outputs never get overwritten.
  always_comb begin
    if (state == DATA) in_rd_req = !in_empty && (!out_valid || out_ready);
    else               in_rd_req = !in_empty;
  end

  assign consume    = in_rd_req;
  assign words_last = (words_left == LEN_WIDTH'(1));
  assign rx_swapped = {in_data[7:0], in_data[15:8]};
  assign frame_drop = (rx_swapped != ETHERTYPE) ||
                      ((MAC_FILTER_EN != 0) && !dst_is_mac && !dst_is_bcast);
  assign dbg_state  = state;

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      state             <= LENGTH;
      words_left        <= '0;
      pay_left          <= '0;
      pay_odd           <= 1'b0;
      first_pend        <= 1'b0;
      dst_is_mac        <= 1'b0;
      dst_is_bcast      <= 1'b0;
      seen_good         <= 1'b0;
      hdr_idx           <= '0;
      seq_expected      <= '0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      out_first         <= 1'b0;
      out_last          <= 1'b0;
      out_odd           <= 1'b0;
      packet_count      <= '0;
      good_packet_count <= '0;
      seq_error_count   <= '0;
      runt_count        <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (consume) begin
        case (state)
          LENGTH: begin
            if (frame_words != '0) begin
              words_left   <= frame_words;
              pay_left     <= payload_words;
              pay_odd      <= payload_odd;
              first_pend   <= 1'b1;
              hdr_idx      <= '0;
              dst_is_mac   <= 1'b1;
              dst_is_bcast <= 1'b1;
              if (runt) begin
                runt_count <= runt_count + 16'd1;
                state      <= DISCARD;
              end else begin
                packet_count <= packet_count + 16'd1;
                state        <= HEADER;
              end
            end
          end
          HEADER: begin
            words_left <= words_left - LEN_WIDTH'(1);
            hdr_idx    <= hdr_idx + 3'd1;
            if (hdr_idx < 3'd3) begin
              dst_is_mac   <= dst_is_mac && (in_data == mac_wire_word(MAC_ADDR, hdr_idx[1:0]));
              dst_is_bcast <= dst_is_bcast && (in_data == 16'hFFFF);
            end
            if (hdr_idx == 3'(HDR_WORDS - 1)) begin
              if (frame_drop) begin
                state <= words_last ? LENGTH : DISCARD;
              end else begin
                good_packet_count <= good_packet_count + 16'd1;
                if (SEQ_ENABLE != 0)      state <= SEQ;
                else if (pay_left == '0)  state <= words_last ? LENGTH : DISCARD;
                else                      state <= DATA;
              end
            end
          end
          SEQ: begin
            words_left <= words_left - LEN_WIDTH'(1);
            if (seen_good && (rx_swapped != seq_expected))
              seq_error_count <= seq_error_count + 16'd1;
            seq_expected <= rx_swapped + 16'd1;
            seen_good    <= 1'b1;
            if (pay_left == '0) state <= words_last ? LENGTH : DISCARD;
            else                state <= DATA;
          end
          DATA: begin
            words_left <= words_left - LEN_WIDTH'(1);
            pay_left   <= pay_left - LEN_WIDTH'(1);
            first_pend <= 1'b0;
            out_data   <= in_data;
            out_valid  <= 1'b1;
            out_first  <= first_pend;
            out_last   <= (pay_left == LEN_WIDTH'(1));
            out_odd    <= (pay_left == LEN_WIDTH'(1)) && pay_odd;
            if (pay_left == LEN_WIDTH'(1)) state <= words_last ? LENGTH : DISCARD;
          end
          DISCARD: begin
            words_left <= words_left - LEN_WIDTH'(1);
            if (words_last) state <= LENGTH;
          end
          default: state <= LENGTH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtdf_packet_filter.sv
// Scoreboard bench for rtdf_packet_filter: FIFO model feeds frames, monitor checks output words.
module tb_rtdf_packet_filter;
  import rtdf_pkg::*;

  logic        clk_rx = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_empty = 1'b1;
  logic        in_rd_req;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first;
  logic        out_last;
  logic        out_odd;
  logic [15:0] packet_count;
  logic [15:0] good_packet_count;
  logic [15:0] seq_error_count;
  logic [15:0] runt_count;
  logic [2:0]  dbg_state;

  logic [15:0] fifo_q[$];
  logic [18:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          consumed = 0;
  int          hold_viol = 0;
  int          stall_cycles = 0;
  bit          rand_ready = 1'b0;

  always #5 clk_rx = ~clk_rx;

  rtdf_packet_filter dut (
    .clk_rx            (clk_rx),
    .reset             (reset),
    .in_data           (in_data),
    .in_empty          (in_empty),
    .in_rd_req         (in_rd_req),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_first         (out_first),
    .out_last          (out_last),
    .out_odd           (out_odd),
    .packet_count      (packet_count),
    .good_packet_count (good_packet_count),
    .seq_error_count   (seq_error_count),
    .runt_count        (runt_count),
    .dbg_state         (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Show-ahead FIFO model: present head at negedge, pop after the edge that consumed it.
  initial begin : feeder
    logic pop;
    forever begin
      @(negedge clk_rx);
      in_empty  = (fifo_q.size() == 0);
      in_data   = in_empty ? 16'h0 : fifo_q[0];
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      pop = in_rd_req && !in_empty;
      if (out_valid && !out_ready) stall_cycles++;
      if (dbg_state == DATA && out_valid && !out_ready && in_rd_req) hold_viol++;
      @(posedge clk_rx);
      if (pop) begin
        void'(fifo_q.pop_front());
        consumed++;
      end
    end
  end

  initial begin : monitor
    forever begin
      logic [18:0] e;
      @(negedge clk_rx);
      #2;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_word{first,last,odd,data}",
                {13'b0, out_first, out_last, out_odd, out_data}, {13'b0, e});
        end
      end
    end
  end

  task automatic send_frame(input int len, input logic [15:0] etype, input logic [15:0] seq,
                            input bit expect_out);
    int w, p, pw;
    logic [15:0] d;
    w  = (len + 1) / 2;
    p  = len - 20;
    pw = (p + 1) / 2;
    fifo_q.push_back(16'(len));
    fifo_q.push_back(16'h0201);
    fifo_q.push_back(16'h0403);
    fifo_q.push_back(16'h0605);
    for (int k = 0; k < 3; k++) fifo_q.push_back(16'h1111);
    fifo_q.push_back({etype[7:0], etype[15:8]});
    fifo_q.push_back({seq[7:0], seq[15:8]});
    for (int k = 0; k < pw; k++) begin
      d = {8'(2 * k + 1), 8'(2 * k)} ^ seq;
      fifo_q.push_back(d);
      if (expect_out) exp_q.push_back({k == 0, k == pw - 1, (k == pw - 1) && (p % 2 == 1), d});
    end
    for (int k = 8 + pw; k < w; k++) fifo_q.push_back(16'hC3C3);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !out_valid) && n < 3000) begin
      @(negedge clk_rx);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: got fifo=%0d exp=%0d pending expected 0", name, fifo_q.size(),
               exp_q.size());
    end
    repeat (3) @(negedge clk_rx);
  endtask

  task automatic check_counts(input string name, input int pk, input int gd, input int se,
                              input int rn);
    check({name, "_packet_count"}, packet_count, 32'(pk));
    check({name, "_good_packet_count"}, good_packet_count, 32'(gd));
    check({name, "_seq_error_count"}, seq_error_count, 32'(se));
    check({name, "_runt_count"}, runt_count, 32'(rn));
  endtask

  initial begin : main
    int c0;
    reset = 1'b1;
    repeat (3) @(negedge clk_rx);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_flags", {out_first, out_last, out_odd}, 0);
    check("reset_in_rd_req_empty", in_rd_req, 0);
    check_counts("reset", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk_rx);

    send_frame(64, 16'h88B5, 16'd5, 1);
    wait_idle("l64_seq5");
    check_counts("l64_seq5", 1, 1, 0, 0);

    send_frame(65, 16'h88B5, 16'd7, 1);
    wait_idle("l65_seq7");
    check_counts("l65_seq7", 2, 2, 1, 0);

    send_frame(64, 16'h0800, 16'd8, 0);
    wait_idle("ipv4_drop");
    check_counts("ipv4_drop", 3, 2, 1, 0);

    send_frame(64, 16'h88B5, 16'd8, 1);
    wait_idle("seq8");
    check_counts("seq8", 4, 3, 1, 0);

    send_frame(64, 16'h88B5, 16'hFFFF, 1);
    wait_idle("seq_ffff");
    check_counts("seq_ffff", 5, 4, 2, 0);

    send_frame(64, 16'h88B5, 16'h0000, 1);
    wait_idle("seq_wrap0");
    check_counts("seq_wrap0", 6, 5, 2, 0);

    // Runt: L=10 is the length word plus 5 frame words.
    c0 = consumed;
    fifo_q.push_back(16'd10);
    for (int k = 0; k < 5; k++) fifo_q.push_back(16'hEEEE);
    wait_idle("runt");
    check("runt_words_consumed", 32'(consumed - c0), 6);
    check_counts("runt", 6, 5, 2, 1);

    c0 = consumed;
    fifo_q.push_back(16'h0000);
    wait_idle("zero_len");
    check("zero_len_consumed", 32'(consumed - c0), 1);
    check_counts("zero_len", 6, 5, 2, 1);

    send_frame(20, 16'h88B5, 16'd1, 0);
    wait_idle("no_payload");
    check_counts("no_payload", 7, 6, 2, 1);

    rand_ready = 1'b1;
    send_frame(64, 16'h88B5, 16'd2, 1);
    wait_idle("rand_ready");
    rand_ready = 1'b0;
    check_counts("rand_ready", 8, 7, 2, 1);
    check("rand_ready_rd_while_held", 32'(hold_viol), 0);
    check("rand_ready_saw_stall", 32'(stall_cycles > 0), 1);

    // Abandon a frame part-way through its header.
    fifo_q.push_back(16'd64);
    for (int k = 0; k < 4; k++) fifo_q.push_back(16'h5A5A);
    wait_idle("partial");
    check("partial_packet_count", packet_count, 9);
    reset = 1'b1;
    repeat (2) @(negedge clk_rx);
    reset = 1'b0;
    check_counts("mid_reset", 0, 0, 0, 0);
    send_frame(64, 16'h88B5, 16'h1234, 1);
    wait_idle("after_reset");
    check_counts("after_reset", 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
